// File: rtl/seven_seg_readback.sv
// Passive monitor of a multiplexed active-low 4-digit seven-segment bus.
// Rebuilds the displayed hex value once each {An,Seg} sample has been stable long enough.
module seven_seg_readback #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 4
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [3:0]  An,
    input  logic [0:6]  Seg,
    output logic [15:0] HexVal,
    output logic [3:0]  DigitValid,
    output logic [3:0]  BadPattern,
    output logic        FrameDone,
    output logic        SegErr
);

    localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(STABLE_CYCLES);

    // sample layout: [10:7] = An, [6:0] = segments a..g with a in bit 6
    logic [10:0]      sample_r;
    logic [10:0]      sample_p;
    logic [CNT_W-1:0] stable_cnt;
    logic [3:0]       captured_mask;

    logic             fire;
    logic [3:0]       digit_sel;
    logic             single_digit;
    logic             blanked;
    logic             seg_off;
    logic             seg_legal;
    logic [3:0]       seg_value;
    logic [3:0]       mask_next;

    always_comb begin
        fire = (sample_r == sample_p) && (stable_cnt == STABLE_MAX - 1'b1);

        digit_sel = 4'b0000;
        case (sample_r[10:7])
            4'b1110: digit_sel = 4'b0001;
            4'b1101: digit_sel = 4'b0010;
            4'b1011: digit_sel = 4'b0100;
            4'b0111: digit_sel = 4'b1000;
            default: digit_sel = 4'b0000;
        endcase
        single_digit = |digit_sel;
        blanked      = (sample_r[10:7] == 4'b1111);
        seg_off      = (sample_r[6:0] == 7'b111_1111);

        seg_legal = 1'b1;
        seg_value = 4'h0;
        case (sample_r[6:0])
            7'b0000001: seg_value = 4'h0;
            7'b1001111: seg_value = 4'h1;
            7'b0010010: seg_value = 4'h2;
            7'b0000110: seg_value = 4'h3;
            7'b1001100: seg_value = 4'h4;
            7'b0100100: seg_value = 4'h5;
            7'b0100000: seg_value = 4'h6;
            7'b0001111: seg_value = 4'h7;
            7'b0000000: seg_value = 4'h8;
            7'b0000100: seg_value = 4'h9;
            7'b0001000: seg_value = 4'hA;
            7'b1100000: seg_value = 4'hB;
            7'b0110001: seg_value = 4'hC;
            7'b1000010: seg_value = 4'hD;
            7'b0110000: seg_value = 4'hE;
            7'b0111000: seg_value = 4'hF;
            default:    seg_legal = 1'b0;
        endcase

        mask_next = captured_mask | digit_sel;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sample_r      <= '1;
            sample_p      <= '1;
            stable_cnt    <= '0;
            captured_mask <= 4'b0000;
            HexVal        <= 16'h0000;
            DigitValid    <= 4'b0000;
            BadPattern    <= 4'b0000;
            FrameDone     <= 1'b0;
            SegErr        <= 1'b0;
        end else begin
            sample_r  <= {An, Seg};
            sample_p  <= sample_r;
            FrameDone <= 1'b0;
            SegErr    <= 1'b0;

            if (sample_r != sample_p)
                stable_cnt <= CNT_W'(1);
            else if (stable_cnt != STABLE_MAX)
                stable_cnt <= stable_cnt + 1'b1;

            if (fire) begin
                if (single_digit) begin
                    for (int i = 0; i < 4; i++) begin
                        if (digit_sel[i]) begin
                            if (seg_legal) begin
                                HexVal[4*i +: 4] <= seg_value;
                                DigitValid[i]    <= 1'b1;
                                BadPattern[i]    <= 1'b0;
                            end else if (seg_off) begin
                                HexVal[4*i +: 4] <= 4'h0;
                                DigitValid[i]    <= 1'b0;
                                BadPattern[i]    <= 1'b0;
                            end else begin
                                DigitValid[i]    <= 1'b0;
                                BadPattern[i]    <= 1'b1;
                            end
                        end
                    end
                    if (!seg_legal && !seg_off)
                        SegErr <= 1'b1;
                    // completing the frame restarts the mask on the same edge
                    if (mask_next == 4'b1111) begin
                        FrameDone     <= 1'b1;
                        captured_mask <= 4'b0000;
                    end else begin
                        captured_mask <= mask_next;
                    end
                end else if (!blanked) begin
                    SegErr <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_readback.sv
// Directed bench for seven_seg_readback: a table of single-digit captures with
// exact-edge timing, then hand-written sequences for glitches, errors and reset.
module tb_seven_seg_readback;

    logic        Clk;
    logic        Reset_n;
    logic [3:0]  An;
    logic [0:6]  Seg;
    logic [15:0] HexVal;
    logic [3:0]  DigitValid;
    logic [3:0]  BadPattern;
    logic        FrameDone;
    logic        SegErr;

    int total = 0;
    int bad   = 0;
    int fd_cnt = 0;
    int se_cnt = 0;

    seven_seg_readback #(.STABLE_CYCLES(4), .CNT_W(4)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .An(An), .Seg(Seg),
        .HexVal(HexVal), .DigitValid(DigitValid), .BadPattern(BadPattern),
        .FrameDone(FrameDone), .SegErr(SegErr)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (FrameDone) fd_cnt++;
        if (SegErr)    se_cnt++;
    end

    typedef struct {
        int         dig;
        logic [6:0] seg;
        logic [3:0] nib;
        logic       keep;
        logic       valid;
        logic       bad;
        logic       err;
        logic       fd;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic show(input logic [3:0] an, input logic [6:0] seg, input int n);
        @(negedge Clk);
        An  = an;
        Seg = seg;
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic idle(input int n);
        show(4'b1111, 7'b1111111, n);
    endtask

    logic [15:0] exp_hex;
    logic [3:0]  exp_valid;
    logic [3:0]  exp_bad;
    int          fd0;
    int          se0;

    initial begin
        vecs[0]  = '{0, 7'b0000001, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1, 7'b1001111, 4'h1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{2, 7'b0010010, 4'h2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{3, 7'b0000110, 4'h3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{0, 7'b1001100, 4'h4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1, 7'b0100100, 4'h5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{2, 7'b0100000, 4'h6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{3, 7'b0001111, 4'h7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{0, 7'b0000000, 4'h8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1, 7'b0000100, 4'h9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{2, 7'b0001000, 4'hA, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{3, 7'b1100000, 4'hB, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{0, 7'b0110001, 4'hC, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{1, 7'b1000010, 4'hD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{2, 7'b0110000, 4'hE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{3, 7'b0111000, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[16] = '{2, 7'b1111110, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[17] = '{1, 7'b1111111, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        // reset with random bus activity
        Reset_n = 1'b0;
        An  = 4'b1111;
        Seg = 7'b1111111;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            An  = 4'($urandom);
            Seg = 7'($urandom);
        end
        #1;
        chk("rst_hex", HexVal, 16'h0000);
        chk("rst_valid", DigitValid, 4'b0000);
        chk("rst_bad", BadPattern, 4'b0000);
        chk("rst_pulses", {FrameDone, SegErr}, 2'b00);
        @(negedge Clk);
        An = 4'b1111;
        Seg = 7'b1111111;
        Reset_n = 1'b1;
        idle(50);
        chk("blank_hex", HexVal, 16'h0000);
        chk("blank_flags", {DigitValid, BadPattern}, 8'h00);
        chk("blank_pulses", fd_cnt + se_cnt, 0);

        // table: every decode entry, bad and blank patterns, with edge-exact timing
        exp_hex = 16'h0000;
        exp_valid = 4'b0000;
        exp_bad = 4'b0000;
        for (int v = 0; v < 18; v++) begin
            @(negedge Clk);
            An  = ~(4'b0001 << vecs[v].dig);
            Seg = vecs[v].seg;
            repeat (4) @(posedge Clk);
            #1;
            chk($sformatf("pre_hex[%0d]", v), HexVal, exp_hex);
            chk($sformatf("pre_valid[%0d]", v), DigitValid, exp_valid);
            chk($sformatf("pre_pulse[%0d]", v), {FrameDone, SegErr}, 2'b00);
            if (!vecs[v].keep) exp_hex[4*vecs[v].dig +: 4] = vecs[v].nib;
            exp_valid[vecs[v].dig] = vecs[v].valid;
            exp_bad[vecs[v].dig]   = vecs[v].bad;
            @(posedge Clk);
            #1;
            chk($sformatf("hex[%0d]", v), HexVal, exp_hex);
            chk($sformatf("valid[%0d]", v), DigitValid, exp_valid);
            chk($sformatf("badpat[%0d]", v), BadPattern, exp_bad);
            chk($sformatf("segerr[%0d]", v), SegErr, vecs[v].err);
            chk($sformatf("framedone[%0d]", v), FrameDone, vecs[v].fd);
        end
        chk("table_hex_final", HexVal, 16'hFE0C);
        idle(4);
        chk("table_fd_count", fd_cnt, 4);
        chk("table_se_count", se_cnt, 1);

        @(negedge Clk);
        Reset_n = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;
        idle(4);

        // clean frame "1A2F"
        fd0 = fd_cnt;
        se0 = se_cnt;
        show(4'b0111, 7'b1001111, 8);
        show(4'b1011, 7'b0001000, 8);
        show(4'b1101, 7'b0010010, 8);
        chk("frame_no_early_fd", fd_cnt, fd0);
        show(4'b1110, 7'b0111000, 8);
        idle(3);
        chk("frame_hex", HexVal, 16'h1A2F);
        chk("frame_valid", DigitValid, 4'b1111);
        chk("frame_fd_once", fd_cnt, fd0 + 1);
        chk("frame_no_err", se_cnt, se0);

        // 3-cycle glitches of an "8" on a different digit between digits
        fd0 = fd_cnt;
        show(4'b0111, 7'b1001111, 8);
        show(4'b1110, 7'b0000000, 3);
        show(4'b1011, 7'b0001000, 8);
        show(4'b0111, 7'b0000000, 3);
        show(4'b1101, 7'b0010010, 8);
        show(4'b1011, 7'b0000000, 3);
        show(4'b1110, 7'b0111000, 8);
        show(4'b1101, 7'b0000000, 3);
        idle(4);
        chk("glitch_hex", HexVal, 16'h1A2F);
        chk("glitch_fd", fd_cnt, fd0 + 1);
        chk("glitch_no_err", se_cnt, se0);

        // bad pattern on digit 2, blank on digit 1 (mask afterwards = 0110)
        show(4'b1011, 7'b1111110, 8);
        idle(2);
        chk("bad_badpat", BadPattern, 4'b0100);
        chk("bad_se_once", se_cnt, se0 + 1);
        chk("bad_hex_kept", HexVal, 16'h1A2F);
        show(4'b1101, 7'b1111111, 8);
        idle(2);
        chk("blank_hex1", HexVal, 16'h1A0F);
        chk("blank_valid", DigitValid, 4'b1001);
        chk("blank_no_err", se_cnt, se0 + 1);

        // two anodes low: one SegErr, nothing else changes
        fd0 = fd_cnt;
        se0 = se_cnt;
        show(4'b1100, 7'b1001111, 10);
        idle(2);
        chk("multi_se_once", se_cnt, se0 + 1);
        chk("multi_hex", HexVal, 16'h1A0F);
        chk("multi_no_fd", fd_cnt, fd0);
        show(4'b0111, 7'b0000110, 8);
        idle(2);
        chk("multi_mask_kept_a", fd_cnt, fd0);
        show(4'b1110, 7'b1001100, 8);
        idle(2);
        chk("multi_mask_kept_b", fd_cnt, fd0 + 1);
        chk("multi_hex_after", HexVal, 16'h3A04);

        // reset in the middle of a frame
        show(4'b0111, 7'b1001111, 8);
        show(4'b1011, 7'b0010010, 8);
        @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        chk("midrst_hex", HexVal, 16'h0000);
        @(negedge Clk);
        Reset_n = 1'b1;
        fd0 = fd_cnt;
        show(4'b1101, 7'b0001111, 8);
        show(4'b1110, 7'b0000000, 8);
        idle(3);
        chk("midrst_no_fd", fd_cnt, fd0);
        show(4'b0111, 7'b0100100, 8);
        show(4'b1011, 7'b0100000, 8);
        idle(3);
        chk("midrst_fd", fd_cnt, fd0 + 1);
        chk("midrst_hex_final", HexVal, 16'h5678);
        chk("midrst_valid", DigitValid, 4'b1111);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seven_seg_readback.md
Name: seven_seg_readback

Overview:
- Receiving end of the multiplexed seven-segment display interface: passively monitors the active-low anode and segment bus driven to the Basys3 4-digit display.
- Reconstructs the 16-bit hex value being shown, with per-digit valid and error flags.
- Used for self-check and for loop-back verification of the display path in the stopwatch levels.
- Segment encoding is the team's standard active-low a..g table, with Seg bit 0 = a and bit 6 = g.

Parameters:
- STABLE_CYCLES, 4: number of consecutive identical registered samples of {An,Seg} required before a capture; legal range 2..15.
- CNT_W, 4: width of the stability counter; must hold STABLE_CYCLES.

Ports:
- Clk  input  1  system clock.
- Reset_n  input  1  asynchronous active-low reset.
- An  input  4  anode enables, active low; An[0] = rightmost digit (HexVal[3:0]).
- Seg  input  7 ([0:6])  segment lines, active low; bit0=a … bit6=g.
- HexVal  output  16  reconstructed value; nibble i belongs to digit i.
- DigitValid  output  4  bit i = 1 when nibble i came from a legal hex pattern.
- BadPattern  output  4  bit i = 1 when the last capture for digit i was an unrecognised pattern.
- FrameDone  output  1  one-cycle pulse when all four digits have been captured since the last pulse.
- SegErr  output  1  one-cycle pulse on a bad pattern or multi-anode capture.

Behaviour:
- Reset (async, Reset_n=0): HexVal=16'h0000, DigitValid=4'b0000, BadPattern=4'b0000, FrameDone=0, SegErr=0, captured-mask=0, stability counter=0, input register=all ones.
- Input stage:
  - {An,Seg} is registered once per Clk (Sr).
  - Previous sample is held in Sp.
- Stability counter:
  - If Sr != Sp, the counter clears to 1.
  - Otherwise it increments, saturating at STABLE_CYCLES.
  - A capture fires on the single cycle the counter reaches STABLE_CYCLES, i.e. exactly once per stable window.
  - Timing: a value first present at An/Seg before edge k is captured, and outputs reflect it, after edge k+STABLE_CYCLES.
  - Runs shorter than STABLE_CYCLES (ghosting, transitions) never capture.
- Capture classification on a firing cycle:
  - An = 4'b1111 (blanked): no capture, no flags, mask unchanged.
  - Exactly one An bit low (digit i), Seg in table 0..F: HexVal[4i+3:4i] = decoded value, DigitValid[i]=1, BadPattern[i]=0, mask[i]=1.
  - Exactly one An bit low, Seg = 7'b111_1111 (digit off): nibble cleared to 0, DigitValid[i]=0, BadPattern[i]=0, mask[i]=1.
  - Exactly one An bit low, any other Seg: nibble unchanged, DigitValid[i]=0, BadPattern[i]=1, mask[i]=1, SegErr pulses.
  - Two or more An bits low: no register update, mask unchanged, SegErr pulses.
- Decode table (Seg a..g → value):
  - 0000001→0, 1001111→1, 0010010→2, 0000110→3
  - 1001100→4, 0100100→5, 0100000→6, 0001111→7
  - 0000000→8, 0000100→9, 0001000→A, 1100000→B
  - 0110001→C, 1000010→D, 0110000→E, 0111000→F
- FrameDone:
  - When a capture makes mask = 4'b1111, FrameDone=1 for that one cycle and mask clears to 0 on the same edge.
  - Repeated captures of the same digit before the frame completes are allowed; the latest value wins.
- Output registration: all outputs are registered; SegErr and FrameDone are pulses of exactly one Clk cycle and may coincide.
- Reset mid-capture: the stability count and mask are lost; the next frame restarts from an empty mask.

Test Plan:
- Reset check: hold Reset_n=0 with random An/Seg → HexVal=0000, DigitValid=0, BadPattern=0, no pulses; release and hold An=1111 for 50 cycles → outputs unchanged.
- Clean frame: drive digits 3..0 showing "1A2F" (An=0111/1011/1101/1110, 8 cycles each, STABLE_CYCLES=4) → HexVal=16'h1A2F, DigitValid=1111, exactly one FrameDone after digit 0; each nibble updates 4 edges after its pattern first appears.
- Glitch rejection: insert 3-cycle runs of Seg=0000000 between digits → no captures from the glitches; HexVal stays 16'h1A2F.
- Bad and blank patterns: show digit 2 with Seg=1111110, then digit 1 with Seg=1111111 → BadPattern=0100, SegErr one pulse, nibble 2 unchanged; nibble 1 = 0 with DigitValid[1]=0 and no SegErr.
- Multi-anode: An=1100 stable 10 cycles → single SegErr pulse, HexVal and mask unchanged, no FrameDone.
- Reset mid-frame: capture digits 3 and 2, assert Reset_n for 1 cycle, then capture 1 and 0 → no FrameDone until all four digits are recaptured after reset.
